mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, 28: block-address width (word address with the 4-bit byte offset dropped).
REQ-002 SHALL have parameter BLOCK_W, 128: cache block width in bits.
REQ-003 SHALL have port CLK  input  1  single clock; all state changes on posedge.
REQ-004 SHALL have port RESET  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port I_MEM_READ  input  1  instruction-cache read request.
REQ-006 SHALL have port I_MEM_ADDRESS  input  ADDR_W  instruction-cache block address.
REQ-007 SHALL have port I_MEM_READDATA  output  BLOCK_W  block returned to the instruction cache.
REQ-008 SHALL have port I_MEM_BUSYWAIT  output  1  stall to the instruction cache.
REQ-009 SHALL have port D_MEM_READ  input  1  data-cache read request.
REQ-010 SHALL have port D_MEM_WRITE  input  1  data-cache write-back request.
REQ-011 SHALL have port D_MEM_ADDRESS  input  ADDR_W  data-cache block address.
REQ-012 SHALL have port D_MEM_WRITEDATA  input  BLOCK_W  write-back block.
REQ-013 SHALL have port D_MEM_READDATA  output  BLOCK_W  block returned to the data cache.
REQ-014 SHALL have port D_MEM_BUSYWAIT  output  1  stall to the data cache.
REQ-015 SHALL have ports MEM_READ/MEM_WRITE  output  1 each  request to shared main memory.
REQ-016 SHALL have ports MEM_ADDRESS  output  ADDR_W; MEM_WRITEDATA  output  BLOCK_W: to main memory.
REQ-017 SHALL have ports MEM_READDATA  input  BLOCK_W; MEM_BUSYWAIT  input  1: from main memory.

Function
REQ-018 SHALL implement a registered FSM with states IDLE, SERVE_I, SERVE_D and RELEASE, plus registers LAST_GRANT (I/D) and SEEN_BUSY.
REQ-019 SHALL define I_REQ = I_MEM_READ and D_REQ = D_MEM_READ | D_MEM_WRITE.
REQ-020 In IDLE: only I_REQ -> SERVE_I; only D_REQ -> SERVE_D; both -> grant the requester not equal to LAST_GRANT (round-robin); neither -> IDLE.
REQ-021 On entering SERVE_x, SHALL set LAST_GRANT = x and clear SEEN_BUSY.
REQ-022 In SERVE_I, SHALL drive MEM_READ=1, MEM_WRITE=0, MEM_ADDRESS=I_MEM_ADDRESS combinationally.
REQ-023 In SERVE_D, SHALL pass D_MEM_READ, D_MEM_WRITE, D_MEM_ADDRESS and D_MEM_WRITEDATA through; if both READ and WRITE are high, SHALL drive MEM_WRITE only.
REQ-024 In IDLE and RELEASE, SHALL drive MEM_READ=0 and MEM_WRITE=0; MEM_ADDRESS and MEM_WRITEDATA SHALL hold their last driven values.
REQ-025 SHALL set SEEN_BUSY at any posedge in SERVE_x where MEM_BUSYWAIT=1.
REQ-026 DONE SHALL be (state SERVE_x) & SEEN_BUSY & !MEM_BUSYWAIT; DONE SHALL be ignored before memory has signalled busy at least once.
REQ-027 On DONE, SHALL go to RELEASE on the next edge; RELEASE SHALL always go to IDLE after one cycle, giving memory one idle cycle between transactions.
REQ-028 If the granted requester drops its request in SERVE_x before DONE, SHALL go to RELEASE (abort) without completing.
REQ-029 x_MEM_BUSYWAIT SHALL be x_REQ & !(state==SERVE_x & DONE), combinational, so a waiting or ungranted requester stalls in the same cycle it raises a request.
REQ-030 I_MEM_READDATA and D_MEM_READDATA SHALL both equal MEM_READDATA; each cache samples only when its own BUSYWAIT is low.
REQ-031 A request raised in RELEASE SHALL be arbitrated in the following IDLE cycle; minimum grant-to-grant spacing is 3 cycles.
REQ-032 A non-granted requester SHALL never cause MEM_READ or MEM_WRITE to assert.

Reset
REQ-033 When RESET=1 at posedge, SHALL set state=IDLE, LAST_GRANT=I (first tie goes to D) and SEEN_BUSY=0, overriding any transaction in progress.
REQ-034 While RESET is high, SHALL drive MEM_READ=0, MEM_WRITE=0, MEM_ADDRESS=0, MEM_WRITEDATA=0, and both BUSYWAIT outputs=0.

Verification
REQ-035 I-miss alone: I_MEM_READ=1, address 0x0000010, memory busy for 5 cycles -> MEM_READ=1 and MEM_ADDRESS=0x0000010; I_MEM_BUSYWAIT drops in the cycle MEM_BUSYWAIT falls; next state RELEASE, then IDLE.
REQ-036 Simultaneous requests after reset: I read 0x10 and D write 0x20 in the same cycle -> D served first (MEM_WRITE=1), I_MEM_BUSYWAIT stays 1 throughout; I served after RELEASE.
REQ-037 Round-robin: with both requests held continuously for 4 transactions -> grant order D, I, D, I.
REQ-038 D read and write both asserted -> only MEM_WRITE=1 at memory; MEM_READ=0.
REQ-039 Reset mid-SERVE_D (2 cycles into a 5-cycle access) -> next cycle IDLE, all outputs 0; a following I request is granted.
REQ-040 Early-low busy: MEM_BUSYWAIT=0 in the first SERVE_I cycle, then high for 3 cycles -> no completion until the first low cycle after the high period.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one main-memory port between an instruction
// cache (read-only) and a data cache (read/write-back).
module mem_arbiter #(
  parameter int unsigned ADDR_W  = 28,
  parameter int unsigned BLOCK_W = 128
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               I_MEM_READ,
  input  logic [ADDR_W-1:0]  I_MEM_ADDRESS,
  output logic [BLOCK_W-1:0] I_MEM_READDATA,
  output logic               I_MEM_BUSYWAIT,
  input  logic               D_MEM_READ,
  input  logic               D_MEM_WRITE,
  input  logic [ADDR_W-1:0]  D_MEM_ADDRESS,
  input  logic [BLOCK_W-1:0] D_MEM_WRITEDATA,
  output logic [BLOCK_W-1:0] D_MEM_READDATA,
  output logic               D_MEM_BUSYWAIT,
  output logic               MEM_READ,
  output logic               MEM_WRITE,
  output logic [ADDR_W-1:0]  MEM_ADDRESS,
  output logic [BLOCK_W-1:0] MEM_WRITEDATA,
  input  logic [BLOCK_W-1:0] MEM_READDATA,
  input  logic               MEM_BUSYWAIT
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SERVE_I = 2'd1;
  localparam logic [1:0] SERVE_D = 2'd2;
  localparam logic [1:0] RELEASE = 2'd3;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  logic [1:0]         state;
  logic [1:0]         state_next;
  logic               last_grant;
  logic               last_grant_next;
  logic               seen_busy;
  logic               seen_busy_next;
  logic [ADDR_W-1:0]  addr_q;
  logic [BLOCK_W-1:0] wdata_q;

  logic               i_req;
  logic               d_req;
  logic               serving;
  logic               done;
  logic               mem_read_c;
  logic               mem_write_c;
  logic [ADDR_W-1:0]  mem_addr_c;
  logic [BLOCK_W-1:0] mem_wdata_c;

  assign i_req   = I_MEM_READ;
  assign d_req   = D_MEM_READ | D_MEM_WRITE;
  assign serving = (state == SERVE_I) || (state == SERVE_D);
  // Completion only counts once memory has acknowledged with busy at least once.
  assign done    = serving & seen_busy & ~MEM_BUSYWAIT;

  // State, arbitration history and the held memory-side address/data.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      last_grant <= GRANT_I;
      seen_busy  <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state      <= state_next;
      last_grant <= last_grant_next;
      seen_busy  <= seen_busy_next;
      addr_q     <= mem_addr_c;
      wdata_q    <= mem_wdata_c;
    end
  end

  // Next-state logic with round-robin tie break.
  always_comb begin
    state_next      = state;
    last_grant_next = last_grant;
    seen_busy_next  = seen_busy;
    case (state)
      IDLE: begin
        if (i_req && (!d_req || (last_grant == GRANT_D))) begin
          state_next      = SERVE_I;
          last_grant_next = GRANT_I;
          seen_busy_next  = 1'b0;
        end else if (d_req) begin
          state_next      = SERVE_D;
          last_grant_next = GRANT_D;
          seen_busy_next  = 1'b0;
        end
      end
      SERVE_I: begin
        if (MEM_BUSYWAIT) seen_busy_next = 1'b1;
        if (!i_req || done) state_next = RELEASE;
      end
      SERVE_D: begin
        if (MEM_BUSYWAIT) seen_busy_next = 1'b1;
        if (!d_req || done) state_next = RELEASE;
      end
      RELEASE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Memory-side request mux; address and data hold outside a grant.
  always_comb begin
    mem_read_c  = 1'b0;
    mem_write_c = 1'b0;
    mem_addr_c  = addr_q;
    mem_wdata_c = wdata_q;
    case (state)
      SERVE_I: begin
        mem_read_c = 1'b1;
        mem_addr_c = I_MEM_ADDRESS;
      end
      SERVE_D: begin
        mem_read_c  = D_MEM_READ & ~D_MEM_WRITE;
        mem_write_c = D_MEM_WRITE;
        mem_addr_c  = D_MEM_ADDRESS;
        mem_wdata_c = D_MEM_WRITEDATA;
      end
      default: begin
        mem_read_c  = 1'b0;
        mem_write_c = 1'b0;
      end
    endcase
  end

  assign MEM_READ      = ~RESET & mem_read_c;
  assign MEM_WRITE     = ~RESET & mem_write_c;
  assign MEM_ADDRESS   = RESET ? '0 : mem_addr_c;
  assign MEM_WRITEDATA = RESET ? '0 : mem_wdata_c;

  // Stall any requester until its own grant completes.
  assign I_MEM_BUSYWAIT = ~RESET & i_req & ~((state == SERVE_I) & done);
  assign D_MEM_BUSYWAIT = ~RESET & d_req & ~((state == SERVE_D) & done);

  assign I_MEM_READDATA = MEM_READDATA;
  assign D_MEM_READDATA = MEM_READDATA;

endmodule
